// File: rtl/tour_pkg.sv
// Shared Knight-tour definitions: command encodings, headings, ack value and
// the command sequencer state type.
package tour_pkg;

  localparam logic [15:0] CAL_GYRO        = 16'h2000;
  localparam logic [3:0]  OP_MOVE         = 4'h4;
  localparam logic [3:0]  OP_MOVE_FANFARE = 4'h5;

  localparam logic [7:0] NORTH = 8'h00;
  localparam logic [7:0] WEST  = 8'h3F;
  localparam logic [7:0] SOUTH = 8'h7F;
  localparam logic [7:0] EAST  = 8'hBF;

  localparam logic [7:0] POS_ACK = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StWaitSnt,
    StWaitResp,
    StCheck,
    StErr
  } seq_state_e;

  function automatic logic [15:0] mk_cmd(input logic [3:0] opcode, input logic [7:0] heading,
                                         input logic [3:0] squares);
    return {opcode, heading, squares};
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full and empty
// are told apart without a separate count.
module cmd_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  // Flush dominates: anything pushed in the flushing clock is discarded too.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/rmt_cmd_seq.sv
// Plays a queue of Knight commands through RemoteComm one at a time, waiting
// for a positive acknowledge before issuing the next.
module rmt_cmd_seq #(
  parameter int unsigned DEPTH        = 16,
  parameter logic [23:0] RESP_TIMEOUT = 24'd4_000_000,
  parameter logic [7:0]  POS_ACK      = tour_pkg::POS_ACK
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [15:0]            wr_cmd,
  output logic                   full,
  output logic                   empty,
  input  logic                   start,
  input  logic                   abort,
  output logic [15:0]            cmd,
  output logic                   snd_cmd,
  input  logic                   cmd_snt,
  input  logic                   resp_rdy,
  input  logic [7:0]             resp,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [7:0]             err_resp,
  output logic [$clog2(DEPTH):0] cmds_done
);

  import tour_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CntOne = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [23:0] TmoLast = RESP_TIMEOUT - 24'd1;

  seq_state_e    state_q, state_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          snd_cmd_q, snd_cmd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    err_resp_q, err_resp_d;
  logic [CW-1:0] cmds_done_q, cmds_done_d;
  logic [23:0]   tmo_cnt_q, tmo_cnt_d;
  logic [7:0]    resp_q, resp_d;
  logic          abort_q, abort_d;

  logic          fifo_pop, fifo_flush;
  logic          fifo_full, fifo_empty;
  logic [15:0]   fifo_rdata;

  cmd_fifo #(
    .Depth (DEPTH),
    .Width (16)
  ) u_cmd_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (wr_en),
    .wdata_i (wr_cmd),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    snd_cmd_d   = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    err_resp_d  = err_resp_q;
    cmds_done_d = cmds_done_q;
    tmo_cnt_d   = tmo_cnt_q;
    resp_d      = resp_q;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;

    case (state_q)
      StIdle: begin
        if (abort) begin
          fifo_flush = 1'b1;
        end else if (start) begin
          err_d       = 1'b0;
          err_resp_d  = 8'h00;
          cmds_done_d = '0;
          if (fifo_empty) done_d = 1'b1;
          else            state_d = StLoad;
        end
      end
      StLoad: begin
        cmd_d     = fifo_rdata;
        fifo_pop  = 1'b1;
        snd_cmd_d = 1'b1;
        state_d   = StIssue;
      end
      StIssue: state_d = StWaitSnt;
      StWaitSnt: begin
        if (cmd_snt) begin
          tmo_cnt_d = '0;
          state_d   = StWaitResp;
        end
      end
      StWaitResp: begin
        tmo_cnt_d = tmo_cnt_q + 24'd1;
        // A response arriving on the timeout clock still counts.
        if (resp_rdy) begin
          resp_d  = resp;
          state_d = StCheck;
        end else if (tmo_cnt_q == TmoLast) begin
          err_d      = 1'b1;
          err_resp_d = 8'h00;
          state_d    = StErr;
        end
      end
      StCheck: begin
        if (resp_q == POS_ACK) begin
          cmds_done_d = cmds_done_q + CntOne;
          if (abort_q || abort) begin
            fifo_flush = 1'b1;
            state_d    = StIdle;
          end else if (!fifo_empty) begin
            state_d = StLoad;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end else begin
          err_d      = 1'b1;
          err_resp_d = resp_q;
          state_d    = StErr;
        end
      end
      StErr: begin
        err_d      = 1'b1;
        fifo_flush = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    abort_d = (state_d == StIdle) ? 1'b0 : (abort_q | abort);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cmd_q       <= 16'h0000;
      snd_cmd_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_resp_q  <= 8'h00;
      cmds_done_q <= '0;
      tmo_cnt_q   <= '0;
      resp_q      <= 8'h00;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      snd_cmd_q   <= snd_cmd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_resp_q  <= err_resp_d;
      cmds_done_q <= cmds_done_d;
      tmo_cnt_q   <= tmo_cnt_d;
      resp_q      <= resp_d;
      abort_q     <= abort_d;
    end
  end

  assign full      = fifo_full;
  assign empty     = fifo_empty;
  assign cmd       = cmd_q;
  assign snd_cmd   = snd_cmd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_resp  = err_resp_q;
  assign cmds_done = cmds_done_q;

endmodule

// File: tb/tb_rmt_cmd_seq.sv
// Directed bench for rmt_cmd_seq with a hand-driven RemoteComm responder.
module tb_rmt_cmd_seq;
  import tour_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int          TMO   = 1000;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [15:0] wr_cmd;
  logic        full, empty;
  logic        start, abort;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt, resp_rdy;
  logic [7:0]  resp;
  logic        busy, done, err;
  logic [7:0]  err_resp;
  logic [4:0]  cmds_done;

  int n_checks = 0;
  int n_fail = 0;
  int snd_total = 0;
  int done_total = 0;

  rmt_cmd_seq #(
    .DEPTH        (DEPTH),
    .RESP_TIMEOUT (24'(TMO)),
    .POS_ACK      (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_cmd    (wr_cmd),
    .full      (full),
    .empty     (empty),
    .start     (start),
    .abort     (abort),
    .cmd       (cmd),
    .snd_cmd   (snd_cmd),
    .cmd_snt   (cmd_snt),
    .resp_rdy  (resp_rdy),
    .resp      (resp),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_resp  (err_resp),
    .cmds_done (cmds_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (snd_cmd === 1'b1) snd_total++;
    if (done === 1'b1) done_total++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] c);
    wr_en  = 1'b1;
    wr_cmd = c;
    tick();
    wr_en  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_snd(output logic ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (n < 200 && !ok) begin
      tick();
      n++;
      if (snd_cmd === 1'b1) ok = 1'b1;
    end
  endtask

  // Called while the sequencer sits in WAIT_SNT.
  task automatic respond(input logic [7:0] r, input int dly);
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    repeat (dly) tick();
    resp_rdy = 1'b1;
    resp     = r;
    tick();
    resp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_checks++; if (cmd !== 16'h0000) begin n_fail++; $display("FAIL reset_cmd: got %h want 0000", cmd); end
    n_checks++; if (snd_cmd !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobes: got snd=%b done=%b err=%b want 0", snd_cmd, done, err);
    end
    n_checks++; if (err_resp !== 8'h00 || cmds_done !== 5'd0) begin
      n_fail++; $display("FAIL reset_counts: got err_resp=%h cmds_done=%0d want 00/0", err_resp, cmds_done);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_three_cmds();
    logic [15:0] exp_c [3];
    logic ok;
    int n, s0, d0, exp_lat;
    exp_c = '{CAL_GYRO, 16'h53F4, 16'h47F1};
    for (int i = 0; i < 3; i++) push(exp_c[i]);
    s0 = snd_total;
    d0 = done_total;
    do_start();
    for (int i = 0; i < 3; i++) begin
      exp_lat = (i == 0) ? 2 : 3;
      wait_snd(ok, n);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL three_snd_%0d: got no snd_cmd want strobe", i); end
      n_checks++; if (cmd !== exp_c[i]) begin n_fail++; $display("FAIL three_cmd_%0d: got %h want %h", i, cmd, exp_c[i]); end
      n_checks++; if (n + 1 != exp_lat) begin n_fail++; $display("FAIL three_latency_%0d: got %0d want %0d", i, n + 1, exp_lat); end
      tick();
      n_checks++; if (snd_cmd !== 1'b0) begin n_fail++; $display("FAIL three_snd_width_%0d: got %b want 0", i, snd_cmd); end
      respond(8'hA5, 100);
    end
    repeat (3) tick();
    n_checks++; if (cmds_done !== 5'd3) begin n_fail++; $display("FAIL three_cmds_done: got %0d want 3", cmds_done); end
    n_checks++; if (done_total - d0 != 1) begin n_fail++; $display("FAIL three_done_pulses: got %0d want 1", done_total - d0); end
    n_checks++; if (snd_total - s0 != 3) begin n_fail++; $display("FAIL three_snd_count: got %0d want 3", snd_total - s0); end
    n_checks++; if (err !== 1'b0 || empty !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL three_final: got err=%b empty=%b busy=%b want 0/1/0", err, empty, busy);
    end
  endtask

  task automatic test_bad_resp();
    logic ok;
    int n, s0, d0;
    push(CAL_GYRO);
    push(16'h53F4);
    push(16'h47F1);
    s0 = snd_total;
    d0 = done_total;
    do_start();
    wait_snd(ok, n);
    tick();
    respond(8'hA5, 10);
    wait_snd(ok, n);
    n_checks++; if (cmd !== 16'h53F4) begin n_fail++; $display("FAIL bad_second_cmd: got %h want 53f4", cmd); end
    tick();
    respond(8'h5A, 10);
    repeat (3) tick();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad_err: got %b want 1", err); end
    n_checks++; if (err_resp !== 8'h5A) begin n_fail++; $display("FAIL bad_err_resp: got %h want 5a", err_resp); end
    n_checks++; if (cmds_done !== 5'd1) begin n_fail++; $display("FAIL bad_cmds_done: got %0d want 1", cmds_done); end
    n_checks++; if (empty !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bad_flush: got empty=%b busy=%b want 1/0", empty, busy);
    end
    repeat (20) tick();
    n_checks++; if (snd_total - s0 != 2) begin n_fail++; $display("FAIL bad_snd_count: got %0d want 2", snd_total - s0); end
    n_checks++; if (done_total - d0 != 0) begin n_fail++; $display("FAIL bad_done: got %0d want 0", done_total - d0); end
  endtask

  task automatic test_timeout();
    logic ok;
    int n;
    push(mk_cmd(OP_MOVE, EAST, 4'h2));
    do_start();
    n_checks++; if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL tmo_start_clears: got err=%b busy=%b want 0/1", err, busy);
    end
    wait_snd(ok, n);
    n_checks++; if (cmd !== 16'h4BF2) begin n_fail++; $display("FAIL tmo_cmd: got %h want 4bf2", cmd); end
    tick();
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    repeat (TMO - 1) tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got err=%b want 0", err); end
    tick();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got err=%b want 1", err); end
    n_checks++; if (err_resp !== 8'h00) begin n_fail++; $display("FAIL tmo_err_resp: got %h want 00", err_resp); end
    tick();
    n_checks++; if (busy !== 1'b0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL tmo_idle: got busy=%b empty=%b want 0/1", busy, empty);
    end
  endtask

  task automatic test_full();
    logic ok;
    int n, s0, d0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push(16'(16'h4000 + i));
      if (i == DEPTH - 2) begin
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_early: got %b want 0", full); end
      end
      if (i == DEPTH - 1) begin
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_set: got %b want 1", full); end
      end
    end
    s0 = snd_total;
    d0 = done_total;
    do_start();
    for (int i = 0; i < DEPTH; i++) begin
      wait_snd(ok, n);
      n_checks++; if (cmd !== 16'(16'h4000 + i)) begin
        n_fail++; $display("FAIL full_cmd_%0d: got %h want %h", i, cmd, 16'(16'h4000 + i));
      end
      tick();
      respond(8'hA5, 2);
    end
    repeat (20) tick();
    n_checks++; if (snd_total - s0 != DEPTH) begin n_fail++; $display("FAIL full_snd_count: got %0d want %0d", snd_total - s0, DEPTH); end
    n_checks++; if (cmds_done !== 5'(DEPTH)) begin n_fail++; $display("FAIL full_cmds_done: got %0d want %0d", cmds_done, DEPTH); end
    n_checks++; if (done_total - d0 != 1 || empty !== 1'b1) begin
      n_fail++; $display("FAIL full_final: got done=%0d empty=%b want 1/1", done_total - d0, empty);
    end
  endtask

  task automatic test_abort();
    logic ok;
    int n, s0, d0;
    for (int i = 0; i < 5; i++) push(16'(16'h4101 + i));
    s0 = snd_total;
    d0 = done_total;
    do_start();
    wait_snd(ok, n);
    tick();
    respond(8'hA5, 5);
    wait_snd(ok, n);
    n_checks++; if (cmd !== 16'h4102) begin n_fail++; $display("FAIL abort_second_cmd: got %h want 4102", cmd); end
    tick();
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (5) tick();
    resp_rdy = 1'b1;
    resp     = 8'hA5;
    tick();
    resp_rdy = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (cmds_done !== 5'd2) begin n_fail++; $display("FAIL abort_cmds_done: got %0d want 2", cmds_done); end
    n_checks++; if (empty !== 1'b1 || err !== 1'b0) begin
      n_fail++; $display("FAIL abort_flush: got empty=%b err=%b want 1/0", empty, err);
    end
    repeat (20) tick();
    n_checks++; if (snd_total - s0 != 2 || done_total - d0 != 0) begin
      n_fail++; $display("FAIL abort_counts: got snd=%0d done=%0d want 2/0", snd_total - s0, done_total - d0);
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    int n, s0, d0;
    push(CAL_GYRO);
    push(mk_cmd(OP_MOVE_FANFARE, NORTH, 4'h1));
    do_start();
    wait_snd(ok, n);
    tick();
    n_checks++; if (busy !== 1'b1 || cmd !== CAL_GYRO) begin
      n_fail++; $display("FAIL rst_pre: got busy=%b cmd=%h want 1/2000", busy, cmd);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || snd_cmd !== 1'b0 || cmd !== 16'h0000) begin
      n_fail++; $display("FAIL rst_async: got busy=%b snd=%b cmd=%h want 0/0/0000", busy, snd_cmd, cmd);
    end
    n_checks++; if (empty !== 1'b1 || full !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_flags: got empty=%b full=%b err=%b done=%b want 1/0/0/0", empty, full, err, done);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    s0 = snd_total;
    d0 = done_total;
    do_start();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rst_empty_start_done: got %b want 1", done); end
    tick();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_done_width: got done=%b busy=%b want 0/0", done, busy);
    end
    repeat (10) tick();
    n_checks++; if (snd_total - s0 != 0 || done_total - d0 != 1) begin
      n_fail++; $display("FAIL rst_after_counts: got snd=%0d done=%0d want 0/1", snd_total - s0, done_total - d0);
    end
  endtask

  initial begin
    wr_en    = 1'b0;
    wr_cmd   = 16'h0000;
    start    = 1'b0;
    abort    = 1'b0;
    cmd_snt  = 1'b0;
    resp_rdy = 1'b0;
    resp     = 8'h00;
    test_reset();
    test_three_cmds();
    test_bad_resp();
    test_timeout();
    test_full();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rmt_cmd_seq.md
Name: rmt_cmd_seq

Overview:
Command sequencer directly upstream of RemoteComm. Buffers a queue of 16-bit Knight commands (e.g. CAL_GYRO, 16'h53F4, 16'h47F1) and plays them out one at a time over RemoteComm's snd_cmd/cmd_snt/resp_rdy/resp handshake. It waits for each positive acknowledge before issuing the next command. Used by full-tour benches and by the FPGA remote-controller top level in place of hand-sequenced SendCmd calls.

Parameters:
DEPTH, 16, command queue entries; power of 2, minimum 2.
RESP_TIMEOUT, 24'd4_000_000, clocks allowed between cmd_snt and resp_rdy before error.
POS_ACK, 8'hA5, response value treated as success.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  push wr_cmd into queue
wr_cmd  in  16  command: [15:12] opcode, [11:4] heading, [3:0] squares
full  out  1  queue holds DEPTH entries
empty  out  1  queue holds 0 entries
start  in  1  begin playing queue (honoured only in IDLE)
abort  in  1  stop after current handshake, flush queue
cmd  out  16  to RemoteComm cmd
snd_cmd  out  1  one-clock strobe to RemoteComm
cmd_snt  in  1  RemoteComm finished transmitting
resp_rdy  in  1  RemoteComm received a response byte
resp  in  8  response byte
busy  out  1  high in every state except IDLE
done  out  1  one-clock pulse when the queue has drained with all acks good
err  out  1  sticky; set on bad response or timeout, cleared by start or reset
err_resp  out  8  last bad response byte (8'h00 on timeout)
cmds_done  out  $clog2(DEPTH)+1  count of acknowledged commands since last start

Behaviour:
- Reset: queue empty, pointers 0, state IDLE. cmd=16'h0000. snd_cmd=0, busy=0, done=0, err=0, err_resp=8'h00, cmds_done=0.
- Queue: synchronous FIFO with DEPTH entries. Pointers are $clog2(DEPTH)+1 bits wide; the MSB distinguishes full from empty.
  - wr_en while full is ignored (no overwrite).
  - Simultaneous push and pop in the same clock is legal and leaves the count unchanged.
  - The FIFO pops when the head is loaded into cmd.
- State machine states: IDLE, LOAD, ISSUE, WAIT_SNT, WAIT_RESP, CHECK, ERR.
  - IDLE:
    - start with !empty -> LOAD. This clears err, err_resp and cmds_done.
    - start with empty -> done pulses the next clock; stay in IDLE.
  - LOAD: cmd<=queue head; pop -> ISSUE.
  - ISSUE: snd_cmd=1 for exactly one clock -> WAIT_SNT. cmd stays stable until the next LOAD.
  - WAIT_SNT: on cmd_snt -> WAIT_RESP and clear the timeout counter. There is no timeout in this state.
  - WAIT_RESP:
    - The counter increments each clock.
    - resp_rdy -> CHECK with the resp byte captured.
    - If the counter reaches RESP_TIMEOUT-1 without resp_rdy -> ERR with err_resp=8'h00.
    - If resp_rdy and the timeout occur in the same clock, resp_rdy wins.
  - CHECK:
    - resp==POS_ACK: cmds_done++. Then go to LOAD if !empty; otherwise pulse done and go to IDLE.
    - resp!=POS_ACK: err_resp<=resp -> ERR.
  - ERR: err=1, flush queue (pointers<=0) -> IDLE. done does not pulse.
- abort:
  - Latched while busy.
  - Evaluated only at CHECK. When latched, the queue is flushed and the state returns to IDLE without a done pulse; cmds_done includes the current command if it was acked.
  - abort in IDLE flushes the queue immediately.
- start while busy is ignored.
- wr_en while busy is allowed; pushed commands are played in the same run.
- Latency, start to snd_cmd: 2 clocks (IDLE->LOAD->ISSUE). Ack to the next snd_cmd: 3 clocks (CHECK->LOAD->ISSUE).
- Deasserting rst_n mid-operation returns everything to reset values immediately. Any in-flight RemoteComm transfer is abandoned.

Decomposition:
- Shared tour_pkg holds:
  - Command opcode constants: CAL_GYRO=16'h2000; MOVE opcode 4'h4; MOVE_FANFARE opcode 4'h5.
  - Heading constants: NORTH 8'h00, WEST 8'h3F, SOUTH 8'h7F, EAST 8'hBF.
  - POS_ACK 8'hA5.
  - The state enum typedef.
- One sub-module, cmd_fifo (parameterised DEPTH x 16, full/empty, push/pop/flush), is natural.

Test Plan:
- Push CAL_GYRO, 16'h53F4, 16'h47F1; start; model acks each with 8'hA5 after 100 clocks -> snd_cmd 3 times with cmd in that order, cmds_done=3, done pulses once, err=0, empty=1.
- Second command is answered with resp=8'h5A -> err=1, err_resp=8'h5A, cmds_done=1, queue flushed, third command never sent, no done.
- With RESP_TIMEOUT=1000, no resp_rdy after cmd_snt -> err set exactly 1000 clocks after cmd_snt, err_resp=8'h00, busy drops.
- Push DEPTH+2 commands while idle -> full=1 after DEPTH pushes, extras dropped, exactly DEPTH commands played.
- abort asserted during WAIT_RESP of command 2 of 5; ack good -> cmds_done=2, busy=0 after CHECK, empty=1, no done.
- rst_n pulsed low during WAIT_SNT -> all outputs return to reset values asynchronously; a subsequent start with an empty queue gives a done pulse only.
